// File: rtl/dumbrv_pkg.sv
// rtl/dumbrv_pkg.sv - shared constants, types and frame helpers for the SPI memory master
package dumbrv_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [6:0] frame_bits(input size_e size);
    case (size)
      SZ_BYTE: return 7'd40;
      SZ_HALF: return 7'd48;
      default: return 7'd64;
    endcase
  endfunction

  // Left-aligned frame: cmd, address, then data bytes lowest address first; read data slots are zero.
  function automatic logic [63:0] build_frame(input logic we, input size_e size,
                                              input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    logic [31:0] data;
    data = we ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0;
    case (size)
      SZ_BYTE: data[23:0] = 24'h0;
      SZ_HALF: data[15:0] = 16'h0;
      default: ;
    endcase
    return {(we ? SPI_CMD_WRITE : SPI_CMD_READ), addr, data};
  endfunction

  // The first byte to arrive sits highest in the receive register and belongs at rdata[7:0].
  function automatic logic [31:0] pack_rdata(input size_e size, input logic [31:0] rx);
    case (size)
      SZ_BYTE: return {24'h0, rx[7:0]};
      SZ_HALF: return {16'h0, rx[7:0], rx[15:8]};
      default: return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/dumbrv_spi_mem_if.sv
// rtl/dumbrv_spi_mem_if.sv - request/response bus between the core and the SPI memory master
interface dumbrv_spi_mem_if;
  import dumbrv_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dumbrv_spi_shifter.sv
// rtl/dumbrv_spi_shifter.sv - mode-0 bit engine: SCK divider, TX/RX shift registers and bit counter
module dumbrv_spi_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] frame,
  input  logic [6:0]  nbits,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [31:0] rx_next
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic        sck_q;
  logic [15:0] div_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] tx;
  logic [31:0] rx;
  logic        phase_end;
  logic        bit_end;

  assign phase_end = active && (div_cnt == DIV_LAST);
  // A bit ends on the edge that closes its high phase; MISO is captured on that same edge.
  assign bit_end   = phase_end && sck_q;
  assign done      = bit_end && (bit_cnt == 7'd0);
  assign rx_next   = {rx[30:0], miso};
  assign sck       = sck_q;
  assign mosi      = active & tx[63];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      sck_q   <= 1'b0;
      div_cnt <= 16'd0;
      bit_cnt <= 7'd0;
      tx      <= 64'd0;
      rx      <= 32'd0;
    end else if (start) begin
      active  <= 1'b1;
      sck_q   <= 1'b0;
      div_cnt <= 16'd0;
      bit_cnt <= nbits - 7'd1;
      tx      <= frame;
      rx      <= 32'd0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= 16'd0;
        sck_q   <= ~sck_q;
        if (bit_end) begin
          tx <= {tx[62:0], 1'b0};
          rx <= rx_next;
          if (bit_cnt == 7'd0) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 7'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dumbrv_spi_mem.sv
// rtl/dumbrv_spi_mem.sv - SPI SRAM master turning one byte/half/word request into a READ or WRITE frame
module dumbrv_spi_mem
  import dumbrv_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dumbrv_spi_mem_if.slave   bus,
  output logic              spi_cs,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  state_e      state;
  state_e      state_nxt;
  logic        accept;
  logic        we_q;
  size_e       size_q;
  size_e       req_size_e;
  logic        shift_done;
  logic [31:0] rx_next;
  logic [63:0] frame;
  logic [6:0]  nbits;

  assign req_size_e    = size_e'(bus.req_size);
  assign bus.req_ready = rst_n && (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign frame         = build_frame(bus.req_we, req_size_e, bus.req_addr, bus.req_wdata);
  assign nbits         = frame_bits(req_size_e);

  assign spi_cs        = (state == ST_SHIFT);
  assign bus.rsp_valid = (state == ST_DONE);

  dumbrv_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .frame   (frame),
    .nbits   (nbits),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .done    (shift_done),
    .rx_next (rx_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      size_q        <= SZ_BYTE;
      bus.rsp_rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q   <= bus.req_we;
        size_q <= req_size_e;
      end
      // Capture includes the bit arriving on this final edge, so rdata is ready alongside rsp_valid.
      if ((state == ST_SHIFT) && shift_done && !we_q) begin
        bus.rsp_rdata <= pack_rdata(size_q, rx_next);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (shift_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dumbrv_spi_mem.sv
// tb/tb_dumbrv_spi_mem.sv - scoreboard bench with a 23LC-style SPI SRAM model for dumbrv_spi_mem
module tb_dumbrv_spi_mem;
  import dumbrv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dumbrv_spi_mem_if bus0 ();
  dumbrv_spi_mem_if bus1 ();

  logic cs0, sck0, mosi0, cs1, sck1, mosi1;
  logic miso = 1'b0;

  dumbrv_spi_mem #(.CLK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .spi_cs(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso)
  );

  dumbrv_spi_mem #(.CLK_DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .spi_cs(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  typedef struct {
    logic [63:0] frame;
    int          nbits;
    logic [31:0] rdata;
    logic        rd;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem[int];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       sel = 1'b0;

  logic cs_m, sck_m, mosi_m, rsp_valid_m, ready_m, valid_m;
  logic [31:0] rdata_m;
  assign cs_m        = sel ? cs1 : cs0;
  assign sck_m       = sel ? sck1 : sck0;
  assign mosi_m      = sel ? mosi1 : mosi0;
  assign rsp_valid_m = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign ready_m     = sel ? bus1.req_ready : bus0.req_ready;
  assign valid_m     = sel ? bus1.req_valid : bus0.req_valid;
  assign rdata_m     = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

  logic        cs_p = 1'b0, sck_p = 1'b0;
  int          bitc = 0, rises = 0, acc_cyc = 0, rsp_cnt = 0, ready_viol = 0;
  int          acc_hist[$];
  logic [63:0] cap = '0;
  logic [31:0] sr = '0;
  logic [7:0]  cmd = '0;
  logic [23:0] maddr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'h00;
  endfunction

  // SRAM model plus response monitor, evaluated mid-cycle so every DUT output is settled.
  task automatic model_step();
    int b;
    int off;
    logic [7:0] d;
    exp_t e;
    if (cs_m && !cs_p) begin
      bitc = 0; rises = 0; cap = '0;
    end
    if (cs_m && sck_m && !sck_p) begin
      b = bitc;
      rises++;
      cap = {cap[62:0], mosi_m};
      sr  = {sr[30:0], mosi_m};
      if (b == 7) cmd = sr[7:0];
      if (b == 31) maddr = sr[23:0];
      off = b - 32;
      if (b >= 32 && cmd == 8'h03) begin
        d = mem_rd(maddr + 24'(off / 8));
        miso = d[7 - (off % 8)];
      end else begin
        miso = 1'($urandom);
      end
      if (b >= 32 && cmd == 8'h02 && (off % 8) == 7) mem[int'(maddr + 24'(off / 8))] = sr[7:0];
      bitc++;
    end
    if (valid_m && ready_m) begin
      acc_cyc = cyc;
      acc_hist.push_back(cyc);
    end
    if (ready_m && (cs_m || rsp_valid_m)) ready_viol++;
    if (rsp_valid_m) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        check("mosi_frame", cap, e.frame);
        check("sck_rises", 64'(rises), 64'(e.nbits));
        if (e.rd) check("rdata", 64'(rdata_m), 64'(e.rdata));
      end
      rsp_cnt++;
    end
    cs_p  = cs_m;
    sck_p = sck_m;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic push_exp(input logic we, input logic [1:0] size, input logic [23:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    int nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.frame = 64'({(we ? 8'h02 : 8'h03), addr});
    e.rdata = 32'h0;
    for (int i = 0; i < nb; i++) begin
      e.frame = (e.frame << 8) | 64'(we ? wdata[8*i +: 8] : 8'h00);
      e.rdata = e.rdata | (32'(mem_rd(addr + 24'(i))) << (8 * i));
    end
    e.nbits = 32 + 8 * nb;
    e.rd    = !we;
    e.lat   = e.nbits * 2 * (sel ? 3 : 1) + 1;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic v, input logic we, input logic [1:0] size,
                         input logic [23:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_size = size;
      bus1.req_addr = addr; bus1.req_wdata = wdata;
    end else begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_size = size;
      bus0.req_addr = addr; bus0.req_wdata = wdata;
    end
  endtask

  task automatic wait_cs();
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!cs_m && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cs_m) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rsp_cnt == n && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("rsp_count", 64'(rsp_cnt - n), 1);
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic [23:0] addr,
                         input logic [31:0] wdata);
    int n0;
    n0 = rsp_cnt;
    push_exp(we, size, addr, wdata);
    set_req(1'b1, we, size, addr, wdata);
    wait_cs();
    set_req(1'b0, we, size, addr, wdata);
    wait_rsp(n0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, h0, t;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_size = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_size = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    mem[32'h000100] = 8'h11; mem[32'h000101] = 8'h22;
    mem[32'h000102] = 8'h33; mem[32'h000103] = 8'h44;
    mem[32'h00FFFE] = 8'h5A; mem[32'h010000] = 8'h3C;
    mem[32'h000010] = 8'hBE; mem[32'h000011] = 8'hEF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", 64'(bus0.req_ready), 0);
    check("rst_rsp_valid0", 64'(bus0.rsp_valid), 0);
    check("rst_rdata0", 64'(bus0.rsp_rdata), 0);
    check("rst_cs0", 64'(cs0), 0);
    check("rst_sck0", 64'(sck0), 0);
    check("rst_mosi0", 64'(mosi0), 0);
    check("rst_ready1", 64'(bus1.req_ready), 0);
    check("rst_cs1", 64'(cs1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready0", 64'(bus0.req_ready), 1);

    // word read, byte write at page edge, byte read
    run_req(1'b0, 2'd2, 24'h000100, 32'h0);
    run_req(1'b1, 2'd0, 24'h00FFFF, 32'hDEADBEA5);
    check("mem_ffff", 64'(mem_rd(24'h00FFFF)), 64'h A5);
    check("mem_fffe", 64'(mem_rd(24'h00FFFE)), 64'h5A);
    check("mem_10000", 64'(mem_rd(24'h010000)), 64'h3C);
    run_req(1'b0, 2'd0, 24'h000101, 32'h0);

    // half read through the slow instance
    sel = 1'b1;
    @(posedge clk); #1;
    run_req(1'b0, 2'd1, 24'h000010, 32'h0);
    sel = 1'b0;
    @(posedge clk); #1;

    // back-to-back with req_valid held and wdata disturbed mid-frame
    n0 = rsp_cnt;
    h0 = acc_hist.size();
    ready_viol = 0;
    push_exp(1'b1, 2'd2, 24'h000200, 32'hCAFEF00D);
    set_req(1'b1, 1'b1, 2'd2, 24'h000200, 32'hCAFEF00D);
    wait_cs();
    repeat (20) @(posedge clk);
    #1;
    set_req(1'b1, 1'b1, 2'd2, 24'hABCDEF, 32'hFFFFFFFF);
    t = 0;
    while (!rsp_valid_m && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("first_rsp_seen", 64'(rsp_valid_m), 1);
    push_exp(1'b0, 2'd2, 24'h000200, 32'h0);
    set_req(1'b1, 1'b0, 2'd2, 24'h000200, 32'h0);
    wait_cs();
    set_req(1'b0, 1'b0, 2'd2, 24'h000200, 32'h0);
    wait_rsp(n0 + 1);
    check("ready_while_busy", 64'(ready_viol), 0);
    check("accept_count", 64'(acc_hist.size() - h0), 2);
    if (acc_hist.size() >= h0 + 2)
      check("accept_spacing", 64'(acc_hist[h0 + 1] - acc_hist[h0]), 64'(64 * 2 + 2));
    repeat (2) @(posedge clk);
    #1;

    // reset mid-frame aborts without a response
    n0 = rsp_cnt;
    set_req(1'b1, 1'b0, 2'd2, 24'h000100, 32'h0);
    wait_cs();
    set_req(1'b0, 1'b0, 2'd2, 24'h000100, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    check("ready_in_reset", 64'(bus0.req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_cs", 64'(cs0), 0);
    check("abort_sck", 64'(sck0), 0);
    check("abort_rsp_valid", 64'(bus0.rsp_valid), 0);
    repeat (200) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(rsp_cnt - n0), 0);
    run_req(1'b1, 2'd2, 24'h000300, 32'h89ABCDEF);
    check("mem_300", 64'(mem_rd(24'h000300)), 64'hEF);
    check("mem_303", 64'(mem_rd(24'h000303)), 64'h89);

    // reserved size behaves as word
    run_req(1'b1, 2'd3, 24'h123456, 32'h01020304);
    check("mem_123456", 64'(mem_rd(24'h123456)), 64'h04);
    check("mem_123459", 64'(mem_rd(24'h123459)), 64'h01);
    check("sb_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
